// File: rtl/register_file_mp_if.sv
`default_nettype none
// ============================================================================
//  Module   : register_file_mp_if
//  Purpose  : Bus bundle for the multi-port MIPS register file: read ports,
//             two write ports, step enable and the valid/ready dump stream.
//  Ports    : i_step, i_rd_addr / o_rd_data (NREAD packed ports),
//             i_we0/i_waddr0/i_wdata0, i_we1/i_waddr1/i_wdata1,
//             i_dump_start, i_dump_ready, o_dump_valid, o_dump_addr,
//             o_dump_data, o_dump_busy, o_dump_done
//  Modports : master (pipeline / debug side), slave (register file)
//  Revision : 1.0  initial release
// ============================================================================
interface register_file_mp_if #(
    parameter int REGS  = 5,
    parameter int NBITS = 32,
    parameter int NREAD = 2
);
    logic                     i_step;
    logic [NREAD*REGS-1:0]    i_rd_addr;
    logic [NREAD*NBITS-1:0]   o_rd_data;
    logic                     i_we0;
    logic [REGS-1:0]          i_waddr0;
    logic [NBITS-1:0]         i_wdata0;
    logic                     i_we1;
    logic [REGS-1:0]          i_waddr1;
    logic [NBITS-1:0]         i_wdata1;
    logic                     i_dump_start;
    logic                     i_dump_ready;
    logic                     o_dump_valid;
    logic [REGS-1:0]          o_dump_addr;
    logic [NBITS-1:0]         o_dump_data;
    logic                     o_dump_busy;
    logic                     o_dump_done;

    modport master (
        output i_step, i_rd_addr, i_we0, i_waddr0, i_wdata0,
               i_we1, i_waddr1, i_wdata1, i_dump_start, i_dump_ready,
        input  o_rd_data, o_dump_valid, o_dump_addr, o_dump_data,
               o_dump_busy, o_dump_done
    );

    modport slave (
        input  i_step, i_rd_addr, i_we0, i_waddr0, i_wdata0,
               i_we1, i_waddr1, i_wdata1, i_dump_start, i_dump_ready,
        output o_rd_data, o_dump_valid, o_dump_addr, o_dump_data,
               o_dump_busy, o_dump_done
    );
endinterface
`default_nettype wire

// File: rtl/register_file_mp.sv
`default_nettype none
// ============================================================================
//  Module   : register_file_mp
//  Purpose  : Parametrised MIPS general-purpose register file for the ID
//             stage. NREAD combinational read ports, two prioritised write
//             ports (port 1 wins), optional write-through bypass, optional
//             hardwired $zero, selectable reset image and a valid/ready dump
//             engine that streams every register to the debug UART.
//  Ports    : i_clk    - clock, all state changes on posedge
//             i_reset  - synchronous, active-high reset
//             bus      - register_file_mp_if.slave (read/write/dump signals)
//  Revision : 1.0  initial release
// ============================================================================
module register_file_mp #(
    parameter int REGS       = 5,
    parameter int NBITS      = 32,
    parameter int TAM        = 32,
    parameter int NREAD      = 2,
    parameter int ZERO_REG   = 1,
    parameter int BYPASS     = 1,
    parameter int RESET_MODE = 1
) (
    input  wire logic        i_clk,
    input  wire logic        i_reset,
    register_file_mp_if.slave bus
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [REGS-1:0] c_LAST_IDX = REGS'(TAM - 1);

    logic [NBITS-1:0]       r_regs [TAM];
    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [REGS-1:0]        r_idx;
    logic [REGS-1:0]        w_idx_nxt;
    logic                   w_dump_valid;
    logic                   w_dump_done;
    logic                   w_we0_eff;
    logic                   w_we1_eff;
    logic [NREAD*NBITS-1:0] w_rd_data;

    // Reset image of register k; $zero is forced to 0 when hardwired.
    function automatic logic [NBITS-1:0] f_reset_image(input int k);
        if (RESET_MODE != 0 && !(ZERO_REG != 0 && k == 0))
            return NBITS'(k);
        return '0;
    endfunction

    // Address names a real, writable/readable storage location.
    function automatic logic f_addr_ok(input logic [REGS-1:0] a);
        return (32'(a) < TAM) && !(ZERO_REG != 0 && a == '0);
    endfunction

    // A write only counts when it will actually commit at the next edge;
    // port 0 is dropped when port 1 targets the same location.
    assign w_we1_eff = bus.i_we1 & bus.i_step & ~i_reset & f_addr_ok(bus.i_waddr1);
    assign w_we0_eff = bus.i_we0 & bus.i_step & ~i_reset & f_addr_ok(bus.i_waddr0)
                     & ~(w_we1_eff & (bus.i_waddr0 == bus.i_waddr1));

    // Shared read path used by every read port and by the dump engine, so
    // that bypass and $zero rules are identical everywhere.
    function automatic logic [NBITS-1:0] f_read(input logic [REGS-1:0] a);
        if (!f_addr_ok(a))
            return '0;
        if (BYPASS != 0 && w_we1_eff && bus.i_waddr1 == a)
            return bus.i_wdata1;
        if (BYPASS != 0 && w_we0_eff && bus.i_waddr0 == a)
            return bus.i_wdata0;
        return r_regs[a];
    endfunction

    // ------------------------------------------------------------------
    // Storage
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            for (int k = 0; k < TAM; k++)
                r_regs[k] <= f_reset_image(k);
        end else begin
            if (w_we0_eff)
                r_regs[bus.i_waddr0] <= bus.i_wdata0;
            if (w_we1_eff)
                r_regs[bus.i_waddr1] <= bus.i_wdata1;
        end
    end

    // ------------------------------------------------------------------
    // Read ports
    // ------------------------------------------------------------------
    generate
        for (genvar p = 0; p < NREAD; p++) begin : g_rd
            assign w_rd_data[p*NBITS +: NBITS] = f_read(bus.i_rd_addr[p*REGS +: REGS]);
        end
    endgenerate

    assign bus.o_rd_data = w_rd_data;

    // ------------------------------------------------------------------
    // Dump engine
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= ST_IDLE;
            r_idx   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_idx   <= w_idx_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_idx_nxt    = r_idx;
        w_dump_valid = 1'b0;
        w_dump_done  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (bus.i_dump_start) begin
                    w_state_nxt = ST_SEND;
                    w_idx_nxt   = '0;
                end
            end
            ST_SEND: begin
                w_dump_valid = 1'b1;
                if (bus.i_dump_ready) begin
                    if (r_idx == c_LAST_IDX)
                        w_state_nxt = ST_DONE;
                    else
                        w_idx_nxt = r_idx + 1'b1;
                end
            end
            ST_DONE: begin
                w_dump_done = 1'b1;
                w_state_nxt = ST_IDLE;
                w_idx_nxt   = '0;
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_idx_nxt   = '0;
            end
        endcase
    end

    // Data is read live so a write to the stalled index is presented at once.
    assign bus.o_dump_valid = w_dump_valid;
    assign bus.o_dump_addr  = r_idx;
    assign bus.o_dump_data  = f_read(r_idx);
    assign bus.o_dump_busy  = (r_state != ST_IDLE);
    assign bus.o_dump_done  = w_dump_done;

endmodule
`default_nettype wire

// File: tb/tb_register_file_mp.sv
`default_nettype none
// ============================================================================
//  Module   : tb_register_file_mp
//  Purpose  : Directed self-checking bench for register_file_mp (reset image,
//             bypass, write priority, $zero, dump streaming, reset abort).
//  Revision : 1.0  initial release
// ============================================================================
module tb_register_file_mp;
    localparam int REGS  = 5;
    localparam int NBITS = 32;
    localparam int TAM   = 32;
    localparam int NREAD = 2;

    logic clk = 1'b0;
    logic rst;
    logic rst0;
    always #5 clk = ~clk;

    register_file_mp_if #(.REGS(REGS), .NBITS(NBITS), .NREAD(NREAD)) bus ();
    register_file_mp_if #(.REGS(REGS), .NBITS(NBITS), .NREAD(NREAD)) bus0 ();

    register_file_mp #(
        .REGS(REGS), .NBITS(NBITS), .TAM(TAM), .NREAD(NREAD),
        .ZERO_REG(1), .BYPASS(1), .RESET_MODE(1)
    ) u_dut (
        .i_clk   (clk),
        .i_reset (rst),
        .bus     (bus)
    );

    register_file_mp #(
        .REGS(REGS), .NBITS(NBITS), .TAM(TAM), .NREAD(NREAD),
        .ZERO_REG(1), .BYPASS(1), .RESET_MODE(0)
    ) u_dut0 (
        .i_clk   (clk),
        .i_reset (rst0),
        .bus     (bus0)
    );

    int          n_total = 0;
    int          n_bad   = 0;
    logic [31:0] exp_regs [TAM];

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_rd(input int p, input int a);
        bus.i_rd_addr[p*REGS +: REGS] = REGS'(a);
    endtask

    function automatic logic [31:0] rd(input int p);
        return bus.o_rd_data[p*NBITS +: NBITS];
    endfunction

    // mode 0: ready always high (plus a spurious start mid-dump)
    // mode 1: ready toggles, reg 3 is rewritten while its word is stalled
    task automatic run_dump(input int mode);
        int   nidx, words, busy_cyc, dones, last_hs, done_cyc;
        logic wrote3, wnow;
        nidx = 0; words = 0; busy_cyc = 0; dones = 0;
        last_hs = -10; done_cyc = -1; wrote3 = 1'b0;
        bus.i_dump_ready = (mode == 0);
        bus.i_dump_start = 1'b1;
        tick();
        bus.i_dump_start = 1'b0;
        for (int c = 0; c < 200; c++) begin
            wnow = 1'b0;
            if (mode == 1)
                bus.i_dump_ready = (c % 2 == 1);
            bus.i_dump_start = (mode == 0 && nidx == 5);
            if (mode == 1 && nidx == 3 && !bus.i_dump_ready && !wrote3) begin
                bus.i_we0    = 1'b1;
                bus.i_waddr0 = 5'd3;
                bus.i_wdata0 = 32'h3333_3333;
                exp_regs[3]  = 32'h3333_3333;
                wrote3       = 1'b1;
                wnow         = 1'b1;
            end
            #1;
            if (!bus.o_dump_busy)
                break;
            busy_cyc++;
            if (bus.o_dump_done) begin
                dones++;
                done_cyc = c;
            end
            if (bus.o_dump_valid) begin
                check_val("dump_addr", 32'(bus.o_dump_addr), nidx);
                check_val("dump_data", bus.o_dump_data, exp_regs[nidx % TAM]);
                if (wnow)
                    check_val("stall_write_data", bus.o_dump_data, 32'h3333_3333);
                if (bus.i_dump_ready) begin
                    last_hs = c;
                    words++;
                    nidx++;
                end
            end
            @(posedge clk);
            #1;
            bus.i_we0        = 1'b0;
            bus.i_dump_start = 1'b0;
        end
        check_val("dump_finished", 32'(bus.o_dump_busy), 0);
        check_val("dump_words", words, TAM);
        check_val("dump_done_count", dones, 1);
        check_val("done_latency", done_cyc, last_hs + 1);
        if (mode == 0)
            check_val("busy_cycles", busy_cyc, TAM + 1);
        bus.i_dump_ready = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        rst  = 1'b1;
        rst0 = 1'b1;
        bus.i_step = 1'b0; bus.i_rd_addr = '0;
        bus.i_we0 = 1'b0; bus.i_waddr0 = '0; bus.i_wdata0 = '0;
        bus.i_we1 = 1'b0; bus.i_waddr1 = '0; bus.i_wdata1 = '0;
        bus.i_dump_start = 1'b0; bus.i_dump_ready = 1'b0;
        bus0.i_step = 1'b0; bus0.i_rd_addr = '0;
        bus0.i_we0 = 1'b0; bus0.i_waddr0 = '0; bus0.i_wdata0 = '0;
        bus0.i_we1 = 1'b0; bus0.i_waddr1 = '0; bus0.i_wdata1 = '0;
        bus0.i_dump_start = 1'b0; bus0.i_dump_ready = 1'b0;
        for (int k = 0; k < TAM; k++)
            exp_regs[k] = (k == 0) ? 32'd0 : 32'(k);

        // 1: reset images
        tick();
        tick();
        rst  = 1'b0;
        rst0 = 1'b0;
        set_rd(0, 5);
        set_rd(1, 31);
        bus0.i_rd_addr = {5'd31, 5'd5};
        #1;
        check_val("rst_reg5", rd(0), 32'd5);
        check_val("rst_reg31", rd(1), 32'd31);
        check_val("rst0_reg5", bus0.o_rd_data[31:0], 32'd0);
        check_val("rst0_reg31", bus0.o_rd_data[63:32], 32'd0);
        check_val("rst_dump_valid", 32'(bus.o_dump_valid), 0);
        check_val("rst_dump_busy", 32'(bus.o_dump_busy), 0);
        check_val("rst_dump_done", 32'(bus.o_dump_done), 0);
        check_val("rst_dump_addr", 32'(bus.o_dump_addr), 0);
        check_val("rst_dump_data", bus.o_dump_data, 32'd0);
        set_rd(1, 0);
        #1;
        check_val("rst_reg0", rd(1), 32'd0);

        // 2: bypass and step gating
        bus.i_step = 1'b1;
        bus.i_we0 = 1'b1; bus.i_waddr0 = 5'd7; bus.i_wdata0 = 32'hDEAD_BEEF;
        set_rd(0, 7);
        #1;
        check_val("bypass_same_cycle", rd(0), 32'hDEAD_BEEF);
        tick();
        bus.i_we0 = 1'b0;
        #1;
        check_val("reg7_after_write", rd(0), 32'hDEAD_BEEF);
        exp_regs[7] = 32'hDEAD_BEEF;
        bus.i_step = 1'b0;
        bus.i_we0 = 1'b1; bus.i_wdata0 = 32'h1234_5678;
        #1;
        check_val("nostep_no_bypass", rd(0), 32'hDEAD_BEEF);
        tick();
        bus.i_we0 = 1'b0;
        bus.i_step = 1'b1;
        #1;
        check_val("nostep_unchanged", rd(0), 32'hDEAD_BEEF);

        // 3: write priority and $zero
        bus.i_we0 = 1'b1; bus.i_waddr0 = 5'd9; bus.i_wdata0 = 32'h11;
        bus.i_we1 = 1'b1; bus.i_waddr1 = 5'd9; bus.i_wdata1 = 32'h22;
        set_rd(0, 9);
        #1;
        check_val("prio_bypass", rd(0), 32'h22);
        tick();
        bus.i_we0 = 1'b0; bus.i_we1 = 1'b0;
        #1;
        check_val("prio_reg9", rd(0), 32'h22);
        exp_regs[9] = 32'h22;
        bus.i_we0 = 1'b1; bus.i_waddr0 = 5'd10; bus.i_wdata0 = 32'hA;
        bus.i_we1 = 1'b1; bus.i_waddr1 = 5'd11; bus.i_wdata1 = 32'hB;
        tick();
        bus.i_we0 = 1'b0; bus.i_we1 = 1'b0;
        set_rd(0, 10);
        set_rd(1, 11);
        #1;
        check_val("dual_write_p0", rd(0), 32'hA);
        check_val("dual_write_p1", rd(1), 32'hB);
        exp_regs[10] = 32'hA;
        exp_regs[11] = 32'hB;
        bus.i_we0 = 1'b1; bus.i_waddr0 = 5'd0; bus.i_wdata0 = 32'hFFFF;
        set_rd(0, 0);
        #1;
        check_val("zero_no_bypass", rd(0), 32'd0);
        tick();
        bus.i_we0 = 1'b0;
        #1;
        check_val("zero_after_write", rd(0), 32'd0);

        // 4: full-rate dump
        run_dump(0);

        // 5: stalled dump with a write to the stalled index
        run_dump(1);
        set_rd(0, 3);
        #1;
        check_val("reg3_after_dump", rd(0), 32'h3333_3333);

        // 6: reset in the middle of a dump
        bus.i_dump_ready = 1'b1;
        bus.i_dump_start = 1'b1;
        tick();
        bus.i_dump_start = 1'b0;
        for (int c = 0; c < 40; c++) begin
            if (bus.o_dump_addr == 5'd12)
                break;
            tick();
        end
        check_val("pre_reset_addr", 32'(bus.o_dump_addr), 12);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        bus.i_dump_ready = 1'b0;
        #1;
        check_val("abort_valid", 32'(bus.o_dump_valid), 0);
        check_val("abort_busy", 32'(bus.o_dump_busy), 0);
        check_val("abort_done", 32'(bus.o_dump_done), 0);
        check_val("abort_addr", 32'(bus.o_dump_addr), 0);
        tick();
        check_val("abort_no_late_done", 32'(bus.o_dump_done), 0);
        for (int k = 0; k < TAM; k++)
            exp_regs[k] = (k == 0) ? 32'd0 : 32'(k);
        set_rd(0, 7);
        set_rd(1, 3);
        #1;
        check_val("abort_reg7_image", rd(0), 32'd7);
        check_val("abort_reg3_image", rd(1), 32'd3);
        run_dump(0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
`default_nettype wire
